// File: rtl/multdiv_sched.sv
// Multiply/divide sequencer: latches operands, pulses the selected unit, waits for rdy, returns a tagged result.
// Optional WAIT-state watchdog enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_sched #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic             req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    output logic             busy,
    input  logic             flush,
    output logic [31:0]      unit_a,
    output logic [31:0]      unit_b,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    input  logic             mult_rdy,
    input  logic             div_rdy,
    input  logic [31:0]      mult_result,
    input  logic [31:0]      div_result,
    input  logic             mult_exception,
    input  logic             div_exception,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_exception
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_op;
    logic               r_kill;
    logic [TAG_W-1:0]   r_tag;

    logic               w_rdy;
    logic [31:0]        w_result;
    logic               w_exception;
    logic               w_timeout;
    logic               w_kill_now;

    // Only the selected unit is observed; the other unit's rdy is a don't-care.
    assign w_rdy       = r_op ? div_rdy       : mult_rdy;
    assign w_result    = r_op ? div_result    : mult_result;
    assign w_exception = r_op ? div_exception : mult_exception;
    assign w_kill_now  = r_kill | flush;

`ifdef MULTDIV_TIMEOUT_EN
    localparam logic [5:0] LP_CNT_LAST = 6'(TIMEOUT - 1);
    logic [5:0] r_cnt;
    assign w_timeout = (r_cnt == LP_CNT_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_op         <= 1'b0;
            r_kill       <= 1'b0;
            r_tag        <= '0;
            unit_a       <= '0;
            unit_b       <= '0;
            ctrl_MULT    <= 1'b0;
            ctrl_DIV     <= 1'b0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_tag       <= '0;
            wb_exception <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_kill <= 1'b0;
                    if (req_valid && !flush) begin
                        unit_a    <= req_a;
                        unit_b    <= req_b;
                        r_op      <= req_op;
                        r_tag     <= req_tag;
                        // Pulse is registered here so it is high exactly during START.
                        ctrl_MULT <= ~req_op;
                        ctrl_DIV  <= req_op;
`ifdef MULTDIV_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                        r_state   <= START;
                    end
                end
                START: begin
                    if (flush) r_kill <= 1'b1;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_rdy || w_timeout) begin
                        if (w_kill_now) begin
                            r_kill  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            wb_data      <= w_rdy ? w_result : '0;
                            wb_exception <= w_rdy ? w_exception : 1'b1;
                            wb_tag       <= r_tag;
                            wb_valid     <= 1'b1;
                            r_state      <= DONE;
                        end
                    end else begin
                        if (flush) r_kill <= 1'b1;
`ifdef MULTDIV_TIMEOUT_EN
                        r_cnt <= r_cnt + 6'd1;
`endif
                    end
                end
                DONE: begin
                    if (flush || wb_ready) begin
                        wb_valid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sched.sv
// Directed self-checking bench for multdiv_sched; the unit handshakes are driven by hand.
// Exercises the watchdog path when MULTDIV_TIMEOUT_EN is defined.
module tb_multdiv_sched;

    logic        clock = 1'b0;
    logic        resetn;
    logic        req_valid, req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_tag;
    logic        req_ready, busy, flush;
    logic [31:0] unit_a, unit_b;
    logic        ctrl_MULT, ctrl_DIV;
    logic        mult_rdy, div_rdy;
    logic [31:0] mult_result, div_result;
    logic        mult_exception, div_exception;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic        wb_exception;

    int tests  = 0;
    int errors = 0;
    bit saw_div, saw_wb, bp_ok;

    multdiv_sched #(.TAG_W(5), .TIMEOUT(40)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag), .req_ready(req_ready), .busy(busy), .flush(flush),
        .unit_a(unit_a), .unit_b(unit_b), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .mult_rdy(mult_rdy), .div_rdy(div_rdy),
        .mult_result(mult_result), .div_result(div_result),
        .mult_exception(mult_exception), .div_exception(div_exception),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_tag(wb_tag), .wb_exception(wb_exception)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (ctrl_DIV) saw_div = 1'b1;
        if (wb_valid) saw_wb = 1'b1;
    endtask

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic handshake();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
        req_tag = '0; flush = 1'b0; mult_rdy = 1'b0; div_rdy = 1'b0;
        mult_result = '0; div_result = '0; mult_exception = 1'b0; div_exception = 1'b0;
        wb_ready = 1'b0;
        tick(); tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        resetn = 1'b1;
        tick();

        // Divide 100/7, divider answers 33 cycles after ctrl_DIV
        issue(1'b1, 32'd100, 32'd7, 5'd3);
        check("div_ctrl_DIV_c1", ctrl_DIV, 1);
        check("div_ctrl_MULT_c1", ctrl_MULT, 0);
        check("div_busy_c1", busy, 1);
        tick();
        check("div_ctrl_DIV_c2", ctrl_DIV, 0);
        check("div_unit_a", unit_a, 32'd100);
        check("div_unit_b", unit_b, 32'd7);
        saw_wb = 1'b0;
        repeat (32) tick();
        check("div_no_early_wb", saw_wb, 0);
        div_rdy = 1'b1; div_result = 32'd14;
        tick();
        div_rdy = 1'b0; div_result = '0;
        check("div_wb_valid_c35", wb_valid, 1);
        check("div_wb_data", wb_data, 32'd14);
        check("div_wb_tag", wb_tag, 32'd3);
        check("div_wb_exc", wb_exception, 0);
        check("div_busy_c35", busy, 1);
        handshake();
        check("div_idle_busy", busy, 0);
        check("div_idle_ready", req_ready, 1);
        check("div_idle_wb_valid", wb_valid, 0);

        // Multiply -6*7 with 5 cycles of writeback backpressure
        saw_div = 1'b0;
        issue(1'b0, 32'hFFFF_FFFA, 32'd7, 5'd9);
        check("mul_ctrl_MULT", ctrl_MULT, 1);
        tick(); tick();
        mult_rdy = 1'b1; mult_result = 32'hFFFF_FFD6;
        tick();
        mult_rdy = 1'b0; mult_result = '0;
        bp_ok = 1'b1;
        repeat (5) begin
            if (!wb_valid || wb_data !== 32'hFFFF_FFD6 || unit_a !== 32'hFFFF_FFFA) bp_ok = 1'b0;
            tick();
        end
        check("mul_bp_stable", bp_ok, 1);
        check("mul_wb_data", wb_data, 32'hFFFF_FFD6);
        check("mul_wb_tag", wb_tag, 32'd9);
        handshake();
        check("mul_idle_after_hs", busy, 0);
        check("mul_no_ctrl_DIV", saw_div, 0);

        // Divide by zero: exception passed through, tag kept
        issue(1'b1, 32'd5, 32'd0, 5'd17);
        tick();
        div_rdy = 1'b1; div_exception = 1'b1; div_result = 32'hFFFF_FFFF;
        tick();
        div_rdy = 1'b0; div_exception = 1'b0; div_result = '0;
        check("dz_wb_valid", wb_valid, 1);
        check("dz_wb_exc", wb_exception, 1);
        check("dz_wb_tag", wb_tag, 32'd17);
        check("dz_wb_data", wb_data, 32'hFFFF_FFFF);
        handshake();

        // Flush at cycle 10 of a divide; divider still finishes at cycle 20
        issue(1'b1, 32'd100, 32'd10, 5'd5);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        saw_wb = 1'b0;
        repeat (9) tick();
        check("fl_still_busy", busy, 1);
        div_rdy = 1'b1; div_result = 32'd10;
        tick();
        div_rdy = 1'b0;
        check("fl_idle_busy", busy, 0);
        check("fl_no_wb_valid", saw_wb, 0);
        issue(1'b1, 32'd9, 32'd3, 5'd2);
        tick();
        div_rdy = 1'b1; div_result = 32'd3;
        tick();
        div_rdy = 1'b0; div_result = '0;
        check("fl_next_wb_valid", wb_valid, 1);
        check("fl_next_wb_data", wb_data, 32'd3);
        check("fl_next_wb_tag", wb_tag, 32'd2);
        handshake();

        // Stale mult_rdy held through START must not complete the op
        mult_rdy = 1'b1; mult_result = 32'h0000_DEAD;
        issue(1'b0, 32'd3, 32'd4, 5'd7);
        tick();
        check("st_no_wb_c2", wb_valid, 0);
        check("st_busy_c2", busy, 1);
        mult_rdy = 1'b0; mult_result = 32'd12;
        tick(); tick();
        check("st_no_wb_c4", wb_valid, 0);
        mult_rdy = 1'b1;
        tick();
        mult_rdy = 1'b0;
        check("st_wb_valid", wb_valid, 1);
        check("st_wb_data", wb_data, 32'd12);
        handshake();

        // Flush in DONE wins over a same-cycle wb_ready
        issue(1'b0, 32'd1, 32'd5, 5'd1);
        tick();
        mult_rdy = 1'b1; mult_result = 32'd5;
        tick();
        mult_rdy = 1'b0;
        flush = 1'b1; wb_ready = 1'b1;
        tick();
        flush = 1'b0; wb_ready = 1'b0;
        check("fd_wb_valid", wb_valid, 0);
        check("fd_busy", busy, 0);

`ifdef MULTDIV_TIMEOUT_EN
        // Unit never answers: forced completion after 40 WAIT cycles
        issue(1'b1, 32'd1, 32'd1, 5'd6);
        repeat (40) tick();
        check("to_no_wb_c41", wb_valid, 0);
        tick();
        check("to_wb_valid_c42", wb_valid, 1);
        check("to_wb_data", wb_data, 32'd0);
        check("to_wb_exc", wb_exception, 1);
        check("to_wb_tag", wb_tag, 32'd6);
        handshake();
`else
        // Without the watchdog, a silent unit keeps the controller in WAIT
        saw_wb = 1'b0;
        issue(1'b1, 32'd1, 32'd1, 5'd6);
        repeat (60) tick();
        check("nt_still_busy", busy, 1);
        check("nt_no_wb", saw_wb, 0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
`endif

        // Reset while in WAIT clears everything
        issue(1'b0, 32'd11, 32'd12, 5'd4);
        tick();
        check("rw_unit_a_live", unit_a, 32'd11);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("rw_req_ready", req_ready, 1);
        check("rw_busy", busy, 0);
        check("rw_unit_a", unit_a, 0);
        check("rw_unit_b", unit_b, 0);
        check("rw_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        check("rw_wb_valid", wb_valid, 0);
        check("rw_wb_data", wb_data, 0);
        check("rw_wb_tag", wb_tag, 0);
        check("rw_wb_exc", wb_exception, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_sched.md
# multdiv_sched

Sequencing controller that sits between the execute stage and the shared multiplier/divider units. It accepts one multiply or divide request at a time and holds the operands stable at the units. It issues a single-cycle start pulse (`ctrl_MULT`/`ctrl_DIV`), waits for the selected unit's ready, and captures its result and exception. The result is returned on a valid/ready writeback port tagged with the destination register. The execute stage stalls on `busy`, and a pipeline flush discards an in-flight operation.

## Interface
- `TAG_W`, 5: width of destination-register tag.
- `TIMEOUT`, 40: max WAIT cycles before forced completion (used only with the timeout macro).

- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  execute stage presents an op.
- `req_op`  in  1  0 = multiply, 1 = divide.
- `req_a`, `req_b`  in  32  operands.
- `req_tag`  in  TAG_W  destination register.
- `req_ready`  out  1  accept; high only in IDLE.
- `busy`  out  1  high when state ≠ IDLE; drives pipeline stall.
- `flush`  in  1  kill in-flight op.
- `unit_a`, `unit_b`  out  32  latched operands to both units.
- `ctrl_MULT`, `ctrl_DIV`  out  1  one-cycle start pulses.
- `mult_rdy`, `div_rdy`  in  1  unit result ready.
- `mult_result`, `div_result`  in  32  unit results.
- `mult_exception`, `div_exception`  in  1  unit exceptions.
- `wb_valid`  out  1  result available.
- `wb_ready`  in  1  writeback consumer accepts.
- `wb_data`  out  32  captured result.
- `wb_tag`  out  TAG_W  captured tag.
- `wb_exception`  out  1  captured exception.

## Operation
- States: IDLE, START, WAIT, DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid & ~flush`: latch `req_a`/`req_b` into `unit_a`/`unit_b`, and latch `req_op` and `req_tag`; then go to START.
  - `req_valid & flush` is not accepted.
- **START**
  - Drive `ctrl_MULT` (op=0) or `ctrl_DIV` (op=1) high for exactly this cycle.
  - Go to WAIT.
- **WAIT**
  - Sample only the selected unit's rdy; the other unit's rdy is ignored.
  - On rdy: capture result into `wb_data` and exception into `wb_exception`; go to DONE.
- **DONE**
  - `wb_valid`=1; `wb_data`/`wb_tag`/`wb_exception` held stable.
  - On `wb_ready`: go to IDLE.
- **Operand stability:** `unit_a`/`unit_b` are held constant from acceptance until return to IDLE. The units read them continuously.
- **Flush in START or WAIT:** set a kill flag. The unit cannot be aborted, so wait for its rdy (or timeout), then go straight to IDLE without asserting `wb_valid`. The kill flag clears on return to IDLE.
- **Flush in DONE:** `wb_valid` drops next cycle and the state goes to IDLE, even if `wb_ready` is high the same cycle.
- **Flush in IDLE:** no effect.
- **Exception passthrough:** divide-by-zero is flagged by the divider's own exception and passed through; the result is captured as delivered.
- **Reset** (`resetn`=0 at an edge), from any state:
  - state goes to IDLE; kill flag, timeout counter and all registered outputs go to 0.
  - Post-reset output values: `req_ready`=1, `busy`=0, `ctrl_*`=0, `wb_valid`=0, `wb_data`=0, `wb_tag`=0, `wb_exception`=0, `unit_a`/`unit_b`=0.

## Timing
- Request accepted at edge 0; START occupies cycle 1 (`ctrl_*` pulse); WAIT begins cycle 2.
- rdy sampled high at edge k gives `wb_valid` from cycle k+1.
- Total latency: unit latency + 2 cycles to `wb_valid`.
- rdy is not sampled during START, so a stale rdy from the previous op cannot complete the new one.
- Next request is accepted no earlier than the cycle after the DONE handshake. There is no overlap; maximum throughput is 1 op per (unit latency + 3) cycles.
- All outputs are registered except `req_ready` and `busy`, which decode state.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - A 6-bit counter runs in WAIT and clears on entry to START.
  - If it reaches `TIMEOUT` without rdy, go to DONE with `wb_data`=0 and `wb_exception`=1. If the kill flag is set, go to IDLE instead.
- `MULTDIV_TIMEOUT_EN` undefined: no counter; WAIT lasts until rdy indefinitely.

## Test plan
- **Divide:** `req_op`=1, a=100, b=7, tag=3, divider model rdy 33 cycles after `ctrl_DIV` -> one-cycle `ctrl_DIV` at cycle 1; `wb_valid` at cycle 35 with data=14, tag=3, exception=0; `busy` high cycles 1–35.
- **Multiply with backpressure:** `req_op`=0, a=−6, b=7, `wb_ready` held low 5 cycles -> `wb_data`=−42 stable throughout; IDLE the cycle after the handshake; `ctrl_DIV` never pulses.
- **Divide by zero:** a=5, b=0, unit asserts `div_exception` with rdy -> `wb_exception`=1 and tag preserved.
- **Flush during WAIT:** flush at cycle 10 of a divide -> no `wb_valid`; returns to IDLE the cycle after rdy; next request (a=9, b=3) returns 3.
- **Stale rdy:** `mult_rdy` held high from the previous op during START -> ignored; completion occurs only on rdy sampled in WAIT.
- **Timeout and reset:** with `MULTDIV_TIMEOUT_EN`, TIMEOUT=40, rdy never asserted -> `wb_valid` with data=0, exception=1 at 40 WAIT cycles. Separately, `resetn`=0 in WAIT -> IDLE, `req_ready`=1, all other outputs 0 next cycle.
